// File: rtl/booth4_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package booth4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 64;

  // Booth multiplier windows {b[i+1], b[i], b[i-1]}
  localparam logic [2:0] WIN_ZERO_LO = 3'b000;
  localparam logic [2:0] WIN_P1_A    = 3'b001;
  localparam logic [2:0] WIN_P1_B    = 3'b010;
  localparam logic [2:0] WIN_P2      = 3'b011;
  localparam logic [2:0] WIN_M2      = 3'b100;
  localparam logic [2:0] WIN_M1_A    = 3'b101;
  localparam logic [2:0] WIN_M1_B    = 3'b110;
  localparam logic [2:0] WIN_ZERO_HI = 3'b111;

  // Unsigned operands need one extra window to absorb the zero-extended top bit.
  function automatic int iter_count(input int width, input logic is_signed);
    return is_signed ? (width / 2) : (width / 2 + 1);
  endfunction

endpackage

// File: rtl/booth4code.sv
// Radix-4 Booth encoder: one 3-bit multiplier window selects a signed
// partial product of 0, +/-A or +/-2A.
module booth4code
  import booth4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] a_i,
  input  logic [2:0]         b_i,
  output logic [2*WIDTH:0]   booth_o
);

  logic [2*WIDTH:0] a_ext;

  assign a_ext = {a_i[2*WIDTH-1], a_i};

  // Select the partial product for the current window.
  always_comb begin
    booth_o = '0;
    case (b_i)
      WIN_P1_A, WIN_P1_B: booth_o = a_ext;
      WIN_P2:             booth_o = a_ext << 1'b1;
      WIN_M2:             booth_o = -(a_ext << 1'b1);
      WIN_M1_A, WIN_M1_B: booth_o = -a_ext;
      default:            booth_o = '0;
    endcase
  end

endmodule

// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 Booth multiplier: two multiplier bits per cycle,
// valid/ready handshakes on operand and result sides.
module booth4_seq_mult
  import booth4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 signed_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 2;
  localparam int MW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH / 2 + 2);

  state_t         state;
  logic [PW-1:0]  mcand;
  logic [MW-1:0]  mplier;
  logic [CW-1:0]  iters;
  logic [CW-1:0]  count;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_next;
  logic [AW-1:0]  pp_shifted;
  logic [PW:0]    booth;
  logic [CW:0]    shamt;
  logic           a_ext;
  logic           b_ext;

  booth4code #(
    .WIDTH (WIDTH)
  ) u_booth4code (
    .a_i     (mcand),
    .b_i     (mplier[2:0]),
    .booth_o (booth)
  );

  assign a_ext      = signed_i & a_i[WIDTH-1];
  assign b_ext      = signed_i & b_i[WIDTH-1];
  assign shamt      = {count, 1'b0};
  // Sign-extend the partial product to accumulator width before weighting it.
  assign pp_shifted = {booth[PW], booth} << shamt;
  assign acc_next   = acc + pp_shifted;

  // Control FSM, operand capture, accumulation and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      product_o <= '0;
      acc       <= '0;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      iters     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            mcand   <= {{WIDTH{a_ext}}, a_i};
            mplier  <= {b_ext, b_ext, b_i, 1'b0};
            iters   <= CW'(iter_count(WIDTH, signed_i));
            acc     <= '0;
            count   <= '0;
            state   <= CALC;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 2'd2;
          count  <= count + 1'b1;
          if (count == iters - 1'b1) begin
            state     <= DONE;
            busy_o    <= 1'b0;
            valid_o   <= 1'b1;
            product_o <= acc_next[PW-1:0];
          end
        end
        DONE: begin
          if (valid_o && ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Self-checking bench for booth4_seq_mult: latency-level behavioural model,
// per-cycle output comparison, directed corner cases and random regression.
module tb_booth4_seq_mult;

  logic          clk;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [63:0]   a_i;
  logic [63:0]   b_i;
  logic          signed_i;
  logic          valid_o;
  logic          ready_i;
  logic [127:0]  product_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;

  booth4_seq_mult #(.WIDTH(64)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .signed_i  (signed_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .product_o (product_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    logic [127:0] ua;
    logic [127:0] ub;
    if (s) begin
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      return 128'(sa * sb);
    end
    ua = {64'd0, a};
    ub = {64'd0, b};
    return ua * ub;
  endfunction

  // Behavioural model: an operation is in flight from accept until the
  // result handshake; the result appears K edges after accept.
  int           edge_n = 0;
  bit           m_inflight = 1'b0;
  int           m_done_edge = 0;
  logic [127:0] m_exp = '0;
  logic [127:0] m_prod = '0;

  always @(posedge clk) begin
    edge_n++;
    if (rst_i) begin
      m_inflight = 1'b0;
      m_prod     = '0;
    end else if (!m_inflight) begin
      if (valid_i) begin
        m_inflight  = 1'b1;
        m_done_edge = edge_n + (signed_i ? 32 : 33);
        m_exp       = ref_mul(a_i, b_i, signed_i);
      end
    end else if (edge_n > m_done_edge && ready_i) begin
      m_inflight = 1'b0;
    end else if (edge_n == m_done_edge) begin
      m_prod = m_exp;
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("ctrl_rdy_vld_busy", {125'd0, ready_o, valid_o, busy_o},
            {125'd0, !m_inflight, m_inflight && (edge_n >= m_done_edge),
             m_inflight && (edge_n < m_done_edge)});
      check("product", product_o, m_prod);
    end
  end

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0:       v = 64'd0;
      1:       v = 64'd1;
      2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      4:       v = 64'h8000_0000_0000_0000;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // bp: 0 = random ready_i, 1 = hold ready_i low 10 cycles in DONE, 2 = ready_i high
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic chk, input logic [127:0] lit, input int bp,
                       input logic toggle);
    int guard;
    int lat;
    int first_lat;
    int done_cnt;
    guard = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 128'd0, 128'd1);
    a_i = a; b_i = b; signed_i = s; valid_i = 1'b1; ready_i = 1'b0;
    lat = 0; first_lat = -1; done_cnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      valid_i = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      if (valid_o) begin
        if (first_lat < 0) first_lat = lat;
        case (bp)
          0:       ready_i = ($urandom_range(0, 3) != 0);
          1:       ready_i = (done_cnt >= 10);
          default: ready_i = 1'b1;
        endcase
        done_cnt++;
        if (ready_i) break;
      end else begin
        ready_i = (bp == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      lat++;
    end
    if (lat >= 200) begin
      check("result_timeout", 128'd0, 128'd1);
    end else if (chk) begin
      check("lit_product", product_o, lit);
      check("lit_latency", 128'(first_lat), s ? 128'd32 : 128'd33);
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; signed_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    check("reset_ready", 128'(ready_o), 128'd1);
    check("reset_valid", 128'(valid_o), 128'd0);
    check("reset_busy", 128'(busy_o), 128'd0);
    check("reset_product", product_o, 128'd0);

    do_op(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b1,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, 1, 1'b1);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 2, 1'b1);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, 2, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
          128'hC000_0000_0000_0000_8000_0000_0000_0000, 0, 1'b0);

    // Reset after the 10th CALC edge drops the operation.
    a_i = 64'h1234_5678_9ABC_DEF0; b_i = 64'h0FED_CBA9_8765_4321;
    signed_i = 1'b0; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midrst_ready", 128'(ready_o), 128'd1);
    check("midrst_valid", 128'(valid_o), 128'd0);
    check("midrst_busy", 128'(busy_o), 128'd0);
    check("midrst_product", product_o, 128'd0);
    do_op(64'd7, 64'd6, 1'b0, 1'b1, 128'd42, 2, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      do_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0, 128'd0, 0,
            1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
